// File: rtl/exe_stage_if.sv
// exe_stage_if: bundles the ID/EX pipeline register fields consumed by the
// execute stage together with the results it hands back.
//   master : upstream side (drives the decoded instruction, sees results/stall)
//   slave  : the execute stage itself
interface exe_stage_if;
  logic [3:0]  exe_cmd;          // ALU operation, 0000 = bubble
  logic        mem_r_en;         // LDR: ALU computes address
  logic        mem_w_en;         // STR: ALU computes address
  logic        s;                // update NZCV
  logic        imm;              // I bit of the instruction
  logic [11:0] shifter_operand;  // Val2 source field
  logic [23:0] signed_immediate; // branch offset in words
  logic [31:0] pc;               // PC+4 of the instruction
  logic [31:0] val_rn;
  logic [31:0] val_rm;
  logic [31:0] alu_result;       // result / address / product
  logic [31:0] branch_address;
  logic [3:0]  status;           // {N,Z,C,V}
  logic        exe_stall;        // hold upstream, bubble downstream

  modport master (
    output exe_cmd, mem_r_en, mem_w_en, s, imm, shifter_operand,
           signed_immediate, pc, val_rn, val_rm,
    input  alu_result, branch_address, status, exe_stall
  );

  modport slave (
    input  exe_cmd, mem_r_en, mem_w_en, s, imm, shifter_operand,
           signed_immediate, pc, val_rn, val_rm,
    output alu_result, branch_address, status, exe_stall
  );
endinterface

// File: rtl/exe_stage.sv
// exe_stage: execute stage of the 5-stage ARM pipeline.
// Val2 generator, 33-bit ALU with NZCV flags, branch-target adder, status
// register, and an iterative shift-add multiplier (MUL_BITS multiplier bits
// per cycle) that stalls the upstream pipeline while it runs.
// Ports:
//   clk   - pipeline clock, all state on rising edge
//   reset - synchronous, active-high
//   bus   - exe_stage_if.slave: instruction fields in, result/branch/status/stall out
module exe_stage #(
  parameter int MUL_BITS = 1  // 1, 2, 4 or 8
) (
  input  logic        clk,
  input  logic        reset,
  exe_stage_if.slave  bus
);

  localparam int STEPS = 32 / MUL_BITS;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t  state;
  logic [31:0] acc, mcand, mplier;
  logic [5:0]  cnt;
  logic [3:0]  status_q;

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    ror32 = (n == 5'd0) ? x : ((x >> n) | (x << (6'd32 - {1'b0, n})));
  endfunction

  // ---------------- Val2 ----------------
  logic [11:0] so;
  logic [4:0]  sh_amt;
  logic [31:0] val2;

  assign so     = bus.shifter_operand;
  assign sh_amt = so[11:7];

  always_comb begin
    val2 = bus.val_rm;
    if (bus.mem_r_en || bus.mem_w_en)
      val2 = {{20{so[11]}}, so};
    else if (bus.imm)
      val2 = ror32({24'b0, so[7:0]}, {so[11:8], 1'b0});
    else if (sh_amt != 5'd0) begin
      case (so[6:5])
        2'b00:   val2 = bus.val_rm << sh_amt;
        2'b01:   val2 = bus.val_rm >> sh_amt;
        2'b10:   val2 = $signed(bus.val_rm) >>> sh_amt;
        default: val2 = ror32(bus.val_rm, sh_amt);
      endcase
    end
  end

  // ---------------- ALU ----------------
  logic [31:0] a, res;
  logic [32:0] sum;
  logic        c_in, c_new, v_new;
  logic [3:0]  flags;

  assign a    = bus.val_rn;
  assign c_in = status_q[1];

  always_comb begin
    sum   = '0;
    res   = val2;         // MOV, bubble and unused encodings
    c_new = status_q[1];  // C,V kept unless arithmetic
    v_new = status_q[0];
    case (bus.exe_cmd)
      CMD_MVN: res = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum   = {1'b0, a} + {1'b0, val2} + {32'b0, (bus.exe_cmd == CMD_ADC) & c_in};
        res   = sum[31:0];
        c_new = sum[32];
        v_new = (a[31] == val2[31]) && (res[31] != a[31]);
      end
      // a - b = a + ~b + 1; SBC replaces the +1 with the carry (a - b - ~C)
      CMD_SUB, CMD_SBC: begin
        sum   = {1'b0, a} + {1'b0, ~val2} + {32'b0, (bus.exe_cmd == CMD_SUB) | c_in};
        res   = sum[31:0];
        c_new = sum[32];
        v_new = (a[31] != val2[31]) && (res[31] != a[31]);
      end
      CMD_AND: res = a & val2;
      CMD_ORR: res = a | val2;
      CMD_EOR: res = a ^ val2;
      CMD_MUL: res = acc;
      default: res = val2;
    endcase
  end

  assign flags = {res[31], (res == 32'd0), c_new, v_new};

  // Stall must rise in the same cycle a MUL shows up in IDLE, so it is
  // decoded from the registered state plus the incoming command.
  assign bus.exe_stall = (state == BUSY) ||
                         (state == IDLE && bus.exe_cmd == CMD_MUL);

  // Bubbles never touch the flags even if s happens to be set.
  logic s_eff;
  assign s_eff = bus.s && (bus.exe_cmd != CMD_NOP);

  logic [31:0] digit;
  assign digit = 32'(mplier[MUL_BITS-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= 4'b0;
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
    end else begin
      if (s_eff && !bus.exe_stall) status_q <= flags;
      case (state)
        IDLE: if (bus.exe_cmd == CMD_MUL) begin
          acc    <= '0;
          mcand  <= bus.val_rn;
          mplier <= bus.val_rm;
          cnt    <= '0;
          state  <= BUSY;
        end
        BUSY: begin
          acc    <= acc + mcand * digit;
          mcand  <= mcand << MUL_BITS;
          mplier <= mplier >> MUL_BITS;
          cnt    <= cnt + 6'd1;
          if (cnt == 6'(STEPS - 1)) state <= DONE;
        end
        // Upstream advances on this edge; a following MUL restarts from IDLE.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_result     = res;
  assign bus.status         = status_q;
  assign bus.branch_address = bus.pc + {{6{bus.signed_immediate[23]}}, bus.signed_immediate, 2'b00};

endmodule
